bullet_ctrl: RTL

// Per-tank bullet launcher/mover; the producer end of the collision checker's bullet interface.

---
 rtl/bullet_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bullet_ctrl.sv
// Purpose : per-tank bullet launcher/mover feeding the collision checker and consuming its hit verdict.
// Latency : all outputs registered; spawn visible 1 Clk after a fire edge, each step 1 Clk after frame_tick.
// Backpress: none; fire edges outside IDLE are dropped, hit is only sampled on frame_tick while flying.
// Optional: define BULLET_BOUNCE_EN to let wall/edge contacts reflect the bullet up to MAX_BOUNCE times.
module bullet_ctrl #(
    parameter logic [9:0] STEP       = 10'd5,
    parameter logic [9:0] BULLET_SZ  = 10'd8,
    parameter logic [9:0] TANK_SZ    = 10'd32,
    parameter logic [9:0] X_MAX      = 10'd639,
    parameter logic [9:0] Y_MAX      = 10'd479,
    parameter logic [5:0] COOLDOWN   = 6'd30
`ifdef BULLET_BOUNCE_EN
    ,
    parameter logic [1:0] MAX_BOUNCE = 2'd2
`endif
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] X_Tank,
    input  logic [9:0] Y_Tank,
    input  logic [2:0] tank_dir,
    input  logic [1:0] hit,
    output logic [9:0] X_Bullet,
    output logic [9:0] Y_Bullet,
    output logic [2:0] bullet_dir,
    output logic       bullet_active,
    output logic       score_pulse
);

    // Controller states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FLY   = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;

    // Direction codes shared with the tank and the collision checker
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    // Collision verdict codes; 2'b11 is not produced by the checker and is treated as clear
    localparam logic [1:0] HIT_WALL = 2'b00;
    localparam logic [1:0] HIT_TANK = 2'b10;

    // Offset that centres the bullet on the tank side it leaves from
    localparam logic [9:0] MID = (TANK_SZ - BULLET_SZ) >> 1;

    logic [1:0] state;
    logic [1:0] nxt_state;
    logic       fire_q;
    logic       req;
    logic [2:0] facing;
    logic [2:0] arm_dir;
    logic [2:0] nxt_arm;
    logic [5:0] cool_cnt;
    logic [5:0] nxt_cnt;
    logic [9:0] nxt_x;
    logic [9:0] nxt_y;
    logic [2:0] nxt_dir;
    logic       nxt_act;
    logic       nxt_score;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic [9:0] adv_x;
    logic [9:0] adv_y;
    logic       at_edge;
    logic [10:0] x_far;
    logic [10:0] y_far;

`ifdef BULLET_BOUNCE_EN
    logic [1:0] bounce_cnt;
    logic [1:0] nxt_bounce;

    // Reflection swaps up/down and left/right; anything else cannot be flying
    function automatic logic [2:0] reverse_dir(input logic [2:0] d);
        case (d)
            DIR_UP:    reverse_dir = DIR_DOWN;
            DIR_DOWN:  reverse_dir = DIR_UP;
            DIR_RIGHT: reverse_dir = DIR_LEFT;
            DIR_LEFT:  reverse_dir = DIR_RIGHT;
            default:   reverse_dir = 3'd0;
        endcase
    endfunction
`endif

    // A shot is requested only on the rising edge of the fire key
    assign req = fire & ~fire_q;

    // Fire key history for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
        end
    end

    // Last valid motion direction of the tank; a stationary tank keeps aiming where it last moved
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            facing <= DIR_UP;
        end else if (tank_dir >= DIR_UP && tank_dir <= DIR_DOWN) begin
            facing <= tank_dir;
        end
    end

    // Muzzle position: just outside the tank side it faces, centred on that side,
    // clamped to the screen origin when the tank hugs the top or left border
    always_comb begin
        spawn_x = X_Tank + MID;
        spawn_y = (Y_Tank < BULLET_SZ) ? 10'd0 : (Y_Tank - BULLET_SZ);
        case (facing)
            DIR_RIGHT: begin
                spawn_x = X_Tank + TANK_SZ;
                spawn_y = Y_Tank + MID;
            end
            DIR_LEFT: begin
                spawn_x = (X_Tank < BULLET_SZ) ? 10'd0 : (X_Tank - BULLET_SZ);
                spawn_y = Y_Tank + MID;
            end
            DIR_DOWN: begin
                spawn_x = X_Tank + MID;
                spawn_y = Y_Tank + TANK_SZ;
            end
            default: begin
            end
        endcase
    end

    // Would the next step push the bullet past the screen edge in its direction of travel
    always_comb begin
        x_far   = {1'b0, X_Bullet} + {1'b0, BULLET_SZ} + {1'b0, STEP};
        y_far   = {1'b0, Y_Bullet} + {1'b0, BULLET_SZ} + {1'b0, STEP};
        at_edge = 1'b0;
        case (bullet_dir)
            DIR_UP:    at_edge = (Y_Bullet < STEP);
            DIR_DOWN:  at_edge = (y_far > {1'b0, Y_MAX});
            DIR_LEFT:  at_edge = (X_Bullet < STEP);
            DIR_RIGHT: at_edge = (x_far > {1'b0, X_MAX});
            default:   at_edge = 1'b0;
        endcase
    end

    // Position one step further along the current direction
    always_comb begin
        adv_x = X_Bullet;
        adv_y = Y_Bullet;
        case (bullet_dir)
            DIR_UP:    adv_y = Y_Bullet - STEP;
            DIR_DOWN:  adv_y = Y_Bullet + STEP;
            DIR_LEFT:  adv_x = X_Bullet - STEP;
            DIR_RIGHT: adv_x = X_Bullet + STEP;
            default: begin
            end
        endcase
    end

    // Launch/flight/cooldown sequencing; retirement priority is tank hit, wall hit, screen edge
    always_comb begin
        nxt_state = state;
        nxt_x     = X_Bullet;
        nxt_y     = Y_Bullet;
        nxt_dir   = bullet_dir;
        nxt_act   = bullet_active;
        nxt_score = 1'b0;
        nxt_cnt   = cool_cnt;
        nxt_arm   = arm_dir;
`ifdef BULLET_BOUNCE_EN
        nxt_bounce = bounce_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (req) begin
                    nxt_state = S_ARMED;
                    nxt_x     = spawn_x;
                    nxt_y     = spawn_y;
                    nxt_arm   = facing;
`ifdef BULLET_BOUNCE_EN
                    nxt_bounce = 2'd0;
`endif
                end
            end
            S_ARMED: begin
                // Flight begins on a frame boundary so the first step lines up with the checker
                if (frame_tick) begin
                    nxt_state = S_FLY;
                    nxt_dir   = arm_dir;
                    nxt_act   = 1'b1;
                end
            end
            S_FLY: begin
                if (frame_tick) begin
                    if (hit == HIT_TANK) begin
                        nxt_state = S_COOL;
                        nxt_dir   = 3'd0;
                        nxt_act   = 1'b0;
                        nxt_cnt   = COOLDOWN;
                        nxt_score = 1'b1;
                    end else if (hit == HIT_WALL || at_edge) begin
`ifdef BULLET_BOUNCE_EN
                        if (bounce_cnt < MAX_BOUNCE) begin
                            // Reflect in place; the move resumes on the next tick
                            nxt_dir    = reverse_dir(bullet_dir);
                            nxt_bounce = bounce_cnt + 2'd1;
                        end else begin
                            nxt_state = S_COOL;
                            nxt_dir   = 3'd0;
                            nxt_act   = 1'b0;
                            nxt_cnt   = COOLDOWN;
                        end
`else
                        nxt_state = S_COOL;
                        nxt_dir   = 3'd0;
                        nxt_act   = 1'b0;
                        nxt_cnt   = COOLDOWN;
`endif
                    end else begin
                        nxt_x = adv_x;
                        nxt_y = adv_y;
                    end
                end
            end
            S_COOL: begin
                if (frame_tick) begin
                    if (cool_cnt == 6'd0) begin
                        nxt_state = S_IDLE;
                    end else begin
                        nxt_cnt = cool_cnt - 6'd1;
                    end
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Register state and all outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            X_Bullet      <= 10'd0;
            Y_Bullet      <= 10'd0;
            bullet_dir    <= 3'd0;
            bullet_active <= 1'b0;
            score_pulse   <= 1'b0;
            cool_cnt      <= 6'd0;
            arm_dir       <= DIR_UP;
        end else begin
            state         <= nxt_state;
            X_Bullet      <= nxt_x;
            Y_Bullet      <= nxt_y;
            bullet_dir    <= nxt_dir;
            bullet_active <= nxt_act;
            score_pulse   <= nxt_score;
            cool_cnt      <= nxt_cnt;
            arm_dir       <= nxt_arm;
        end
    end

`ifdef BULLET_BOUNCE_EN
    // Reflections used by the current bullet
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bounce_cnt <= 2'd0;
        end else begin
            bounce_cnt <= nxt_bounce;
        end
    end
`endif

endmodule
